// File: rtl/contador_ctrl.sv
// rtl/contador_ctrl.sv - bounce controller driving an external up/down counter between run-time limits
module contador_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_lo,
  input  logic [3:0] cfg_hi,
  input  logic [1:0] cfg_dwell,
  input  logic [3:0] cfg_cycles,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] cnt_val,
  output logic       cnt_load,
  output logic [3:0] cnt_load_val,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       busy,
  output logic       done,
  output logic       cfg_err,
  output logic [3:0] cycles_left
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UP, S_DWELL_HI, S_DOWN, S_DWELL_LO, S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] lo, hi, cycles;
  logic [1:0] dwell, timer;
  logic       at_hi, at_lo, last_bounce, cfg_ok, accept, run_req, active;

  assign at_hi       = (cnt_val >= hi);
  assign at_lo       = (cnt_val <= lo);
  assign last_bounce = (cycles != 4'd0) && (cycles_left <= 4'd1);
  assign cfg_ok      = (cfg_lo < cfg_hi);
  assign accept      = (state == S_IDLE) && cfg_valid && cfg_ok;
  assign run_req     = (state == S_IDLE) && start && !stop;
  assign active      = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (active && stop) begin
      state_nxt = S_DONE;
    end else begin
      case (state)
        S_IDLE:     if (run_req) state_nxt = S_LOAD;
        S_LOAD:     state_nxt = S_UP;
        S_UP:       if (at_hi) state_nxt = (dwell == 2'd0) ? S_DOWN : S_DWELL_HI;
        S_DWELL_HI: if (timer == 2'd0) state_nxt = S_DOWN;
        S_DOWN: begin
          if (at_lo) begin
            if (last_bounce)         state_nxt = S_DONE;
            else if (dwell == 2'd0)  state_nxt = S_UP;
            else                     state_nxt = S_DWELL_LO;
          end
        end
        S_DWELL_LO: if (timer == 2'd0) state_nxt = S_UP;
        S_DONE:     state_nxt = S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready    = (state == S_IDLE);
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    cnt_load     = 1'b0;
    cnt_load_val = 4'd0;
    cnt_en       = 1'b0;
    cnt_dir      = 1'b0;
    case (state)
      S_LOAD: begin
        cnt_load     = !stop;
        cnt_load_val = lo;
      end
      S_UP: begin
        if (!at_hi) begin
          cnt_en = 1'b1;
        end else if (dwell == 2'd0) begin
          cnt_en  = 1'b1;
          cnt_dir = 1'b1;
        end
      end
      S_DWELL_HI: begin
        cnt_en  = (timer == 2'd0);
        cnt_dir = 1'b1;
      end
      S_DOWN: begin
        if (!at_lo) begin
          cnt_en  = 1'b1;
          cnt_dir = 1'b1;
        end else if (!last_bounce && dwell == 2'd0) begin
          cnt_en = 1'b1;
        end
      end
      S_DWELL_LO: cnt_en = (timer == 2'd0);
      default: ;
    endcase
    // stop overrides every counter command in the cycle it is seen
    if (active && stop) begin
      cnt_en   = 1'b0;
      cnt_load = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lo          <= 4'd0;
      hi          <= 4'd15;
      dwell       <= 2'd1;
      cycles      <= 4'd0;
      cycles_left <= 4'd0;
      timer       <= 2'd0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= (state == S_IDLE) && cfg_valid && !cfg_ok;
      if (accept) begin
        lo          <= cfg_lo;
        hi          <= cfg_hi;
        dwell       <= cfg_dwell;
        cycles      <= cfg_cycles;
        cycles_left <= cfg_cycles;
      end else if (run_req) begin
        cycles_left <= cycles;
      end
      if (!stop) begin
        case (state)
          S_UP:       if (at_hi && dwell != 2'd0) timer <= dwell - 2'd1;
          S_DWELL_HI,
          S_DWELL_LO: if (timer != 2'd0) timer <= timer - 2'd1;
          S_DOWN: begin
            if (at_lo) begin
              if (cycles != 4'd0) cycles_left <= cycles_left - 4'd1;
              if (dwell != 2'd0) timer <= dwell - 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contador_ctrl.sv
// tb/tb_contador_ctrl.sv - directed bench for contador_ctrl with a behavioural 4-bit up/down counter
module tb_contador_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_valid, cfg_ready;
  logic [3:0] cfg_lo, cfg_hi, cfg_cycles;
  logic [1:0] cfg_dwell;
  logic       start, stop;
  logic [3:0] cnt_val;
  logic       cnt_load, cnt_en, cnt_dir;
  logic [3:0] cnt_load_val;
  logic       busy, done, cfg_err;
  logic [3:0] cycles_left;

  int n_tests = 0;
  int n_fail  = 0;

  contador_ctrl dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_dwell(cfg_dwell), .cfg_cycles(cfg_cycles),
    .start(start), .stop(stop), .cnt_val(cnt_val),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
    .busy(busy), .done(done), .cfg_err(cfg_err), .cycles_left(cycles_left)
  );

  always #5 clock = ~clock;

  // external counter, deliberately not tied to the controller reset
  initial cnt_val = 4'd0;
  always @(posedge clock) begin
    if (cnt_load)    cnt_val <= cnt_load_val;
    else if (cnt_en) cnt_val <= cnt_dir ? cnt_val - 4'd1 : cnt_val + 4'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drive a config (optionally with start) for one cycle; returns at the next negedge
  task automatic drive_cfg(input logic [3:0] l, input logic [3:0] h, input logic [1:0] d,
                           input logic [3:0] c, input logic with_start);
    cfg_lo = l; cfg_hi = h; cfg_dwell = d; cfg_cycles = c;
    cfg_valid = 1'b1; start = with_start;
    @(negedge clock);
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulse_stop_and_idle();
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy) begin ok = 1; break; end
    end
    check_eq(tag, ok, 1);
  endtask

  initial begin
    int exp_q[$];
    int hi_runs[$];
    int cl_seq[$];
    int run, done_cnt;
    bit found, err_seen;
    logic [3:0] prev_cl;

    reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_lo = 4'd0; cfg_hi = 4'd0; cfg_dwell = 2'd0; cfg_cycles = 4'd0;
    repeat (2) @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cfg_ready, 1);
    check_eq("rst_en", cnt_en, 0);
    check_eq("rst_load", cnt_load, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", cfg_err, 0);
    check_eq("rst_cl", cycles_left, 0);
    reset = 1'b1;
    @(negedge clock);

    // default config: 0..15, dwell 1, endless
    pulse_start();
    check_eq("dflt_load", cnt_load, 1);
    check_eq("dflt_load_val", cnt_load_val, 0);
    exp_q.push_back(0);
    for (int r = 0; r < 2; r++) begin
      for (int v = 1; v <= 15; v++) exp_q.push_back(v);
      exp_q.push_back(15);
      for (int v = 14; v >= 0; v--) exp_q.push_back(v);
      exp_q.push_back(0);
    end
    foreach (exp_q[k]) begin
      @(negedge clock);
      check_eq("dflt_seq", cnt_val, exp_q[k]);
      check_eq("dflt_nodone", done, 0);
    end
    check_eq("dflt_cl", cycles_left, 0);
    pulse_stop_and_idle();
    check_eq("dflt_stopped", busy, 0);

    // cfg and start together: lo=2 hi=5 dwell=0 one bounce
    drive_cfg(4'd2, 4'd5, 2'd0, 4'd1, 1'b1);
    check_eq("b1_load", cnt_load, 1);
    check_eq("b1_load_val", cnt_load_val, 2);
    exp_q = '{2, 3, 4, 5, 4, 3, 2};
    foreach (exp_q[k]) begin
      @(negedge clock);
      check_eq("b1_seq", cnt_val, exp_q[k]);
    end
    @(negedge clock);
    check_eq("b1_done", done, 1);
    check_eq("b1_hold", cnt_val, 2);
    @(negedge clock);
    check_eq("b1_done_off", done, 0);
    check_eq("b1_idle", busy, 0);
    check_eq("b1_cl", cycles_left, 0);

    // rejected configs keep the previous one
    drive_cfg(4'd3, 4'd3, 2'd1, 4'd2, 1'b0);
    check_eq("err_eq", cfg_err, 1);
    @(negedge clock);
    check_eq("err_pulse", cfg_err, 0);
    pulse_start();
    check_eq("err_old_lo", cnt_load_val, 2);
    wait_idle("err_run_end");
    drive_cfg(4'd9, 4'd4, 2'd0, 4'd1, 1'b0);
    check_eq("err_gt", cfg_err, 1);

    // stop at 7 on the way down
    drive_cfg(4'd0, 4'd15, 2'd3, 4'd2, 1'b1);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (cnt_val == 4'd7 && cnt_dir && cnt_en) begin found = 1; break; end
    end
    check_eq("stop_reach7", found, 1);
    stop = 1'b1;
    #1;
    check_eq("stop_en", cnt_en, 0);
    check_eq("stop_load", cnt_load, 0);
    @(negedge clock);
    stop = 1'b0;
    check_eq("stop_done", done, 1);
    check_eq("stop_val", cnt_val, 7);
    @(negedge clock);
    check_eq("stop_val2", cnt_val, 7);
    check_eq("stop_idle", busy, 0);
    start = 1'b1; stop = 1'b1;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    check_eq("startstop_idle", busy, 0);
    check_eq("startstop_noload", cnt_load, 0);

    // asynchronous reset while holding at hi
    drive_cfg(4'd1, 4'd6, 2'd3, 4'd0, 1'b1);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (cnt_val == 4'd6) begin found = 1; break; end
    end
    check_eq("arst_reach_hi", found, 1);
    @(negedge clock);
    check_eq("arst_in_dwell", busy, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_en", cnt_en, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_load", cnt_load, 0);
    check_eq("arst_load_val", cnt_load_val, 0);
    check_eq("arst_dir", cnt_dir, 0);
    check_eq("arst_cl", cycles_left, 0);
    #1 reset = 1'b1;
    @(negedge clock);
    check_eq("arst_wait", busy, 0);
    check_eq("arst_nodone", done, 0);
    pulse_start();
    check_eq("arst_load_dflt", cnt_load_val, 0);
    @(negedge clock);
    check_eq("arst_reload", cnt_val, 0);
    pulse_stop_and_idle();

    // three bounces with dwell 2; mid-run cfg must be ignored
    drive_cfg(4'd3, 4'd8, 2'd2, 4'd3, 1'b1);
    cl_seq.push_back(int'(cycles_left));
    prev_cl = cycles_left;
    run = 0; done_cnt = 0; err_seen = 0; found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (i == 6) cfg_valid = 1'b0;
      if (cnt_val == 4'd8) run++;
      else if (run > 0) begin hi_runs.push_back(run); run = 0; end
      if (cycles_left != prev_cl) begin cl_seq.push_back(int'(cycles_left)); prev_cl = cycles_left; end
      if (cfg_err) err_seen = 1;
      if (i == 5) begin
        cfg_lo = 4'd0; cfg_hi = 4'd15; cfg_cycles = 4'd0; cfg_valid = 1'b1;
        check_eq("c3_ready", cfg_ready, 0);
      end
      if (done) begin done_cnt++; found = 1; break; end
    end
    check_eq("c3_finished", found, 1);
    check_eq("c3_done_cnt", done_cnt, 1);
    check_eq("c3_hi_visits", hi_runs.size(), 3);
    foreach (hi_runs[k]) check_eq("c3_hi_hold", hi_runs[k], 3);
    check_eq("c3_cl_len", cl_seq.size(), 4);
    foreach (cl_seq[k]) check_eq("c3_cl_seq", cl_seq[k], 3 - k);
    check_eq("c3_no_err", err_seen, 0);
    check_eq("c3_final_lo", cnt_val, 3);
    @(negedge clock);
    check_eq("c3_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
